control_encoder: RTL and testbench

- Transmit-side counterpart of the control decoder; sits between the board request inputs (buttons) and the decoder's ctrl_in.
- Synchronises raw request lines and detects their rising edges.
- Each edge toggles one bit of a held WIDTH-bit control word.
- Each changed word is delivered downstream once over a valid/ready handshake, with coalescing of changes made while a transfer is pending.

---
 rtl/control_pkg.sv | 6 +
 rtl/control_encoder_if.sv | 8 +
 rtl/control_encoder_req_sync_edge.sv | 31 +++
 rtl/control_encoder.sv | 50 +++++
 tb/tb_control_encoder.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/control_pkg.sv
// control_pkg: shared width, FSM encoding and reset word for the control encoder/decoder pair
package control_pkg;
  localparam int CTRL_WIDTH = 4;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} enc_state_e;
  localparam logic [CTRL_WIDTH-1:0] CTRL_INIT = '0;
endpackage

// File: rtl/control_encoder_if.sv
// control_encoder_if: valid/ready word channel from the encoder to the decoder
interface control_encoder_if import control_pkg::*; #(parameter int WIDTH = CTRL_WIDTH);
  logic [WIDTH-1:0] ctrl_out;
  logic ctrl_valid;
  logic ctrl_ready;
  modport master(output ctrl_out, output ctrl_valid, input ctrl_ready);
  modport slave(input ctrl_out, input ctrl_valid, output ctrl_ready);
endinterface

// File: rtl/control_encoder_req_sync_edge.sv
// req_sync_edge: per-line synchroniser with a one-cycle rising-edge pulse output
module req_sync_edge import control_pkg::*; #(
  parameter int WIDTH = CTRL_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic [WIDTH-1:0] req_i,
  output logic [WIDTH-1:0] edge_o
);
  localparam int FW = $clog2(SYNC_STAGES + 2);
  localparam logic [FW-1:0] FULL = FW'(SYNC_STAGES + 1);
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [FW-1:0] fill_q;
  // Edges stay muted until both the synchroniser and the history hold real post-reset samples,
  // so a line held high through reset must go low before it can toggle again.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q[0] <= req_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      fill_q <= (fill_q == FULL) ? fill_q : fill_q + FW'(1);
    end
  end
  assign edge_o = (fill_q == FULL) ? sync_q[SYNC_STAGES-1] & ~prev_q : '0;
endmodule

// File: rtl/control_encoder.sv
// control_encoder: toggles a held control word on request edges and ships each change over valid/ready
module control_encoder import control_pkg::*; #(
  parameter int WIDTH = CTRL_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] INIT = CTRL_INIT
) (
  input  logic clk,
  input  logic rst,
  input  logic [WIDTH-1:0] req,
  control_encoder_if.master ctrl,
  output logic [WIDTH-1:0] ctrl_state,
  output logic [7:0] xfer_cnt
);
  logic [WIDTH-1:0] edg, state_q, state_d, out_q, out_d;
  logic [7:0] cnt_q, cnt_d;
  enc_state_e st_q, st_d;
  logic dirty, acc;
  req_sync_edge #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .req_i(req),
    .edge_o(edg)
  );
  // Dirty compares against the last word sent, so changes during SEND coalesce into one follow-up.
  always_comb begin
    state_d = state_q ^ edg;
    dirty = state_d != out_q;
    acc = (st_q == SEND) & ctrl.ctrl_ready;
    out_d = (dirty & ((st_q == IDLE) | acc)) ? state_d : out_q;
    st_d = (st_q == IDLE) ? (dirty ? SEND : IDLE) : ((acc & ~dirty) ? IDLE : SEND);
    cnt_d = cnt_q + 8'(acc);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      out_q <= INIT;
      st_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      st_q <= st_d;
      cnt_q <= cnt_d;
    end
  end
  assign ctrl.ctrl_out = out_q;
  assign ctrl.ctrl_valid = st_q == SEND;
  assign ctrl_state = state_q;
  assign xfer_cnt = cnt_q;
endmodule

// File: tb/tb_control_encoder.sv
// tb_control_encoder: directed plan scenarios plus random traffic against a transaction-level model
module tb_control_encoder;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req;
  logic [3:0] ctrl_state;
  logic [7:0] xfer_cnt;
  int n_chk = 0, n_err = 0;
  logic [3:0] m_st, m_out;
  logic m_v;
  logic [7:0] m_cnt;
  logic [3:0] hist [$];
  control_encoder_if #(.WIDTH(4)) bus ();
  control_encoder dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .ctrl(bus.master),
    .ctrl_state(ctrl_state),
    .xfer_cnt(xfer_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // A toggle happens when the sample two edges back is high and the one before it low,
  // both taken after the last reset.
  task automatic model_step(input logic r, input logic [3:0] q, input logic rd);
    logic [3:0] e, ns;
    if (r) begin
      m_st = 4'b0000; m_out = 4'b0000; m_v = 1'b0; m_cnt = 8'd0;
      hist.delete();
    end else begin
      e = (hist.size() == 3) ? hist[1] & ~hist[0] : 4'b0000;
      hist.push_back(q);
      if (hist.size() > 3) void'(hist.pop_front());
      ns = m_st ^ e;
      if (m_v && rd) begin
        m_cnt++;
        if (ns == m_out) m_v = 1'b0;
        else m_out = ns;
      end else if (!m_v && ns != m_out) begin
        m_out = ns;
        m_v = 1'b1;
      end
      m_st = ns;
    end
  endtask
  task automatic cyc(input logic r, input logic [3:0] q, input logic rd);
    rst = r; req = q; bus.ctrl_ready = rd;
    @(posedge clk);
    model_step(r, q, rd);
    #1;
    check("ctrl_out", bus.ctrl_out, m_out);
    check("ctrl_valid", bus.ctrl_valid, m_v);
    check("ctrl_state", ctrl_state, m_st);
    check("xfer_cnt", xfer_cnt, m_cnt);
  endtask
  task automatic fresh();
    for (int i = 0; i < 2; i++) cyc(1, 4'b0000, 0);
    for (int i = 0; i < 4; i++) cyc(0, 4'b0000, 0);
  endtask
  initial begin
    int vc, vi;
    logic [3:0] q;
    for (int i = 0; i < 3; i++) cyc(1, 4'b0000, 0);
    check("t1_out", bus.ctrl_out, 4'b0000);
    check("t1_valid", bus.ctrl_valid, 1'b0);
    check("t1_state", ctrl_state, 4'b0000);
    check("t1_cnt", xfer_cnt, 8'd0);
    for (int i = 0; i < 4; i++) cyc(0, 4'b0000, 0);
    vc = 0; vi = -1;
    for (int i = 0; i < 9; i++) begin
      cyc(0, (i < 5) ? 4'b0010 : 4'b0000, 1);
      if (bus.ctrl_valid) begin vc++; vi = i; end
    end
    check("t2_vcycles", vc, 1);
    check("t2_latency", vi, 2);
    check("t2_out", bus.ctrl_out, 4'b0010);
    check("t2_cnt", xfer_cnt, 8'd1);
    fresh();
    cyc(0, 4'b1001, 0);
    for (int i = 0; i < 12; i++) cyc(0, 4'b0000, 0);
    check("t3_out", bus.ctrl_out, 4'b1001);
    check("t3_valid", bus.ctrl_valid, 1'b1);
    cyc(0, 4'b0000, 1);
    check("t3_drop", bus.ctrl_valid, 1'b0);
    check("t3_cnt", xfer_cnt, 8'd1);
    fresh();
    cyc(0, 4'b0001, 0);
    for (int i = 0; i < 3; i++) cyc(0, 4'b0000, 0);
    cyc(0, 4'b0100, 0); cyc(0, 4'b0000, 0); cyc(0, 4'b0000, 0);
    cyc(0, 4'b0100, 0);
    for (int i = 0; i < 4; i++) cyc(0, 4'b0000, 0);
    check("t4_out", bus.ctrl_out, 4'b0001);
    check("t4_state", ctrl_state, 4'b0001);
    for (int i = 0; i < 4; i++) cyc(0, 4'b0000, 1);
    check("t4_valid", bus.ctrl_valid, 1'b0);
    check("t4_cnt", xfer_cnt, 8'd1);
    fresh();
    cyc(0, 4'b0001, 0);
    for (int i = 0; i < 3; i++) cyc(0, 4'b0000, 0);
    cyc(0, 4'b0010, 0); cyc(0, 4'b0000, 0); cyc(0, 4'b0000, 0);
    cyc(0, 4'b0100, 0);
    for (int i = 0; i < 4; i++) cyc(0, 4'b0000, 0);
    check("t5_out0", bus.ctrl_out, 4'b0001);
    check("t5_state", ctrl_state, 4'b0111);
    cyc(0, 4'b0000, 1);
    check("t5_out1", bus.ctrl_out, 4'b0111);
    check("t5_valid1", bus.ctrl_valid, 1'b1);
    check("t5_cnt1", xfer_cnt, 8'd1);
    cyc(0, 4'b0000, 1);
    check("t5_valid2", bus.ctrl_valid, 1'b0);
    check("t5_cnt2", xfer_cnt, 8'd2);
    fresh();
    cyc(0, 4'b0010, 1);
    for (int i = 0; i < 3; i++) cyc(0, 4'b0000, 1);
    cyc(0, 4'b0010, 1);
    for (int i = 0; i < 3; i++) cyc(0, 4'b0000, 1);
    check("t6_cnt_pre", xfer_cnt, 8'd2);
    for (int i = 0; i < 4; i++) cyc(0, 4'b0100, 0);
    check("t6_out_pre", bus.ctrl_out, 4'b0100);
    check("t6_valid_pre", bus.ctrl_valid, 1'b1);
    cyc(1, 4'b1111, 0);
    check("t6_valid_rst", bus.ctrl_valid, 1'b0);
    check("t6_out_rst", bus.ctrl_out, 4'b0000);
    check("t6_cnt_rst", xfer_cnt, 8'd0);
    cyc(1, 4'b1111, 0);
    vc = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 4'b1111, 1);
      if (bus.ctrl_valid) vc++;
    end
    check("t6_no_xfer", vc, 0);
    check("t6_state", ctrl_state, 4'b0000);
    q = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) q[b] = ~q[b];
      cyc($urandom_range(0, 299) == 0, q, $urandom_range(0, 2) != 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
